// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one borrow slice reused over N cycles, LSB first,
// computing DIFF = A - B (mod 2^N) and BORROW = (A < B) behind valid/ready handshakes.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] DIFF,
  output logic         BORROW
);

  // One extra counter bit so the count never wraps when N is a power of two.
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds its payload until that edge.
  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res_sr;
  logic [N-1:0]  res_next;
  logic [CW-1:0] cnt;
  logic          br;
  logic          d;
  logic          br_next;

  always_comb begin
    d       = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  generate
    if (N == 1) begin : g_one
      assign res_next = d;
    end else begin : g_wide
      assign res_next = {d, res_sr[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      DIFF      <= '0;
      BORROW    <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      cnt       <= '0;
      br        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= A;
            b_sr     <= B;
            br       <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          br     <= br_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            DIFF      <= res_next;
            BORROW    <= br_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Leaving DONE only reopens in_ready; operands are taken on a later edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed handshake/timing steps plus randomized traffic,
// scored against an arithmetic model; a second N=1 instance covers the single-bit build.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] op_a = '0;
  logic [N-1:0] op_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] diff;
  logic         borrow;

  logic in_valid1 = 1'b0;
  logic in_ready1;
  logic op_a1 = 1'b0;
  logic op_b1 = 1'b0;
  logic out_valid1;
  logic out_ready1 = 1'b0;
  logic diff1;
  logic borrow1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [N:0] exp_q[$];

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(op_a), .B(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .DIFF(diff), .BORROW(borrow)
  );

  serial_subtractor #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(op_a1), .B(op_b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .DIFF(diff1), .BORROW(borrow1)
  );

  always #5 clk = ~clk;

  // Reference: plain modular arithmetic, borrow is the unsigned compare.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned ai = a;
    int unsigned bi = b;
    logic [N:0] r;
    r[N-1:0] = N'((ai + (1 << N) - bi) % (1 << N));
    r[N]     = (ai < bi);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes seen before the edge, then settle 1ns past it.
  task automatic tick();
    logic [N:0] e;
    if (in_valid && in_ready) exp_q.push_back(model(op_a, op_b));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_diff", 32'(diff), 32'(e[N-1:0]));
        check("sb_borrow", 32'(borrow), 32'(e[N]));
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Accept one operand pair and check latency and result; leaves the DUT in DONE.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_d, input logic exp_b);
    wait_ready();
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = ~a;
    op_b = ~b;
    check("in_ready_calc", 32'(in_ready), 32'd0);
    repeat (N - 1) tick();
    check("early_valid", 32'(out_valid), 32'd0);
    tick();
    check("latency_valid", 32'(out_valid), 32'd1);
    check("diff", 32'(diff), 32'(exp_d));
    check("borrow", 32'(borrow), 32'(exp_b));
  endtask

  task automatic finish_op(input logic [N-1:0] exp_d, input logic exp_b);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
    check("diff_retain", 32'(diff), 32'(exp_d));
    check("borrow_retain", 32'(borrow), 32'(exp_b));
  endtask

  task automatic run_op1(input logic a, input logic b, input logic exp_d, input logic exp_b);
    op_a1 = a;
    op_b1 = b;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    check("n1_calc_valid", 32'(out_valid1), 32'd0);
    @(posedge clk);
    #1;
    check("n1_latency", 32'(out_valid1), 32'd1);
    check("n1_diff", 32'(diff1), 32'(exp_d));
    check("n1_borrow", 32'(borrow1), 32'(exp_b));
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    check("n1_ready_back", 32'(in_ready1), 32'd1);
  endtask

  initial begin
    int acc[3];
    int accepts;
    logic hs;

    // Reset values while rst is held
    #7;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_n1_ready", 32'(in_ready1), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed test plan values
    run_op(4'd9, 4'd3, 4'd6, 1'b0);
    finish_op(4'd6, 1'b0);
    run_op(4'd3, 4'd9, 4'd10, 1'b1);
    finish_op(4'd10, 1'b1);
    run_op(4'd0, 4'd1, 4'd15, 1'b1);
    finish_op(4'd15, 1'b1);
    run_op(4'd15, 4'd15, 4'd0, 1'b0);
    finish_op(4'd0, 1'b0);

    // Backpressure with ignored in_valid traffic
    run_op(4'd3, 4'd9, 4'd10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      op_a = 4'($urandom_range(0, 15));
      op_b = 4'($urandom_range(0, 15));
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_diff", 32'(diff), 32'd10);
      check("bp_borrow", 32'(borrow), 32'd1);
    end
    in_valid = 1'b0;
    finish_op(4'd10, 1'b1);
    run_op(4'd5, 4'd8, 4'd13, 1'b1);
    finish_op(4'd13, 1'b1);

    // Back-to-back with both valids held high for 18 cycles
    wait_ready();
    accepts = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    op_a = 4'($urandom_range(0, 15));
    op_b = 4'($urandom_range(0, 15));
    for (int i = 0; i < 18; i++) begin
      hs = in_ready;
      tick();
      if (hs) begin
        if (accepts < 3) acc[accepts] = cycle;
        accepts++;
        op_a = 4'($urandom_range(0, 15));
        op_b = 4'($urandom_range(0, 15));
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd3);
    if (accepts >= 3) begin
      check("b2b_period1", 32'(acc[1] - acc[0]), 32'd6);
      check("b2b_period2", 32'(acc[2] - acc[1]), 32'd6);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of CALC
    wait_ready();
    op_a = 4'd7;
    op_b = 4'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_borrow", 32'(borrow), 32'd0);
    #2;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    run_op(4'd12, 4'd5, 4'd7, 1'b0);
    finish_op(4'd7, 1'b0);

    // Randomized traffic: operands change every cycle, only handshake values count
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      op_a = 4'($urandom_range(0, 15));
      op_b = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;

    // Single-bit build, all operand combinations
    run_op1(1'b0, 1'b0, 1'b0, 1'b0);
    run_op1(1'b1, 1'b0, 1'b1, 1'b0);
    run_op1(1'b0, 1'b1, 1'b1, 1'b1);
    run_op1(1'b1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
